// File: rtl/ozo_detector_if.sv
// Push-switch inputs and LED output of the 0-1-0 detector, grouped for the board-side hookup.
interface ozo_detector_if;
  logic PUSH_SW_LEFT;
  logic PUSH_SW_RIGHT;
  logic LED;

  modport master (
    output PUSH_SW_LEFT,
    output PUSH_SW_RIGHT,
    input  LED
  );

  modport slave (
    input  PUSH_SW_LEFT,
    input  PUSH_SW_RIGHT,
    output LED
  );
endinterface

// File: rtl/ozo_detector.sv
// Serial 0-1-0 detector fed by two raw push-switches (LEFT = 0, RIGHT = 1) with overlap.
// Each switch is synchronized and edge-detected so a press counts once however long it is held.
module ozo_detector #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rstb,
  ozo_detector_if.slave  sw
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StS0    = 2'd1,
    StS01   = 2'd2,
    StMatch = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] left_sync_q, right_sync_q;
  logic                   left_dly_q, right_dly_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   left_pulse, right_pulse, pulses_valid;
  state_e                 state_q, state_d;
  logic                   led_q;

  // Edges only count once the delayed copy holds a real post-reset sample, so a switch
  // already held at reset release must be seen low before it can produce a pulse.
  assign pulses_valid = fill_q[SYNC_STAGES];
  assign left_pulse   = pulses_valid & left_sync_q[SYNC_STAGES-1] & ~left_dly_q;
  assign right_pulse  = pulses_valid & right_sync_q[SYNC_STAGES-1] & ~right_dly_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      left_sync_q  <= '0;
      right_sync_q <= '0;
      left_dly_q   <= 1'b0;
      right_dly_q  <= 1'b0;
      fill_q       <= '0;
      state_q      <= StIdle;
      led_q        <= 1'b0;
    end else begin
      left_sync_q  <= {left_sync_q[SYNC_STAGES-2:0], sw.PUSH_SW_LEFT};
      right_sync_q <= {right_sync_q[SYNC_STAGES-2:0], sw.PUSH_SW_RIGHT};
      left_dly_q   <= left_sync_q[SYNC_STAGES-1];
      right_dly_q  <= right_sync_q[SYNC_STAGES-1];
      fill_q       <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      state_q      <= state_d;
      led_q        <= (state_d == StMatch);
    end
  end

  // Simultaneous presses are ambiguous and leave the state untouched.
  always_comb begin
    state_d = state_q;
    if (left_pulse ^ right_pulse) begin
      unique case (state_q)
        StIdle:  state_d = right_pulse ? StIdle : StS0;
        StS0:    state_d = right_pulse ? StS01  : StS0;
        StS01:   state_d = right_pulse ? StIdle : StMatch;
        StMatch: state_d = right_pulse ? StS01  : StS0;
        default: state_d = StIdle;
      endcase
    end
  end

  assign sw.LED = led_q;

endmodule

// File: tb/tb_ozo_detector.sv
// Self-checking bench for ozo_detector: directed vector table, corner-case sequences and
// random presses checked against a symbol-history model.
module tb_ozo_detector;

  localparam int KindL    = 0;
  localparam int KindR    = 1;
  localparam int KindBoth = 2;

  logic clk;
  logic rstb;
  ozo_detector_if sw_if ();

  ozo_detector #(.SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rstb (rstb),
    .sw   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int hist[$];

  typedef struct {
    bit rst;
    int kind;
    bit exp_led;
  } vec_t;

  vec_t vecs[16];

  // LED expected iff the last three accepted symbols are 0,1,0.
  function automatic bit model_led();
    int n;
    n = hist.size();
    if (n < 3) return 1'b0;
    return (hist[n-3] == 0) && (hist[n-2] == 1) && (hist[n-1] == 0);
  endfunction

  task automatic check(input string name, input bit exp_led);
    n_total++;
    if (sw_if.LED === exp_led) n_pass++;
    else $display("FAIL %s: LED=%b expected %b at %0t", name, sw_if.LED, exp_led, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    sw_if.PUSH_SW_LEFT  = 1'b0;
    sw_if.PUSH_SW_RIGHT = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    hist.delete();
  endtask

  // Hold the chosen switch(es) high for 'hold' edges, then idle long enough for the LED.
  task automatic press(input int kind, input int hold);
    @(negedge clk);
    sw_if.PUSH_SW_LEFT  = (kind == KindL) || (kind == KindBoth);
    sw_if.PUSH_SW_RIGHT = (kind == KindR) || (kind == KindBoth);
    repeat (hold) @(negedge clk);
    sw_if.PUSH_SW_LEFT  = 1'b0;
    sw_if.PUSH_SW_RIGHT = 1'b0;
    if (kind == KindL) hist.push_back(0);
    else if (kind == KindR) hist.push_back(1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstb    = 1'b0;
    sw_if.PUSH_SW_LEFT  = 1'b0;
    sw_if.PUSH_SW_RIGHT = 1'b0;

    // Full sequence L,R,R,L,R,L,R; overlap L,R,L,R,L; simultaneous after L,R.
    vecs[0]  = '{1'b1, KindL, 1'b0};
    vecs[1]  = '{1'b0, KindR, 1'b0};
    vecs[2]  = '{1'b0, KindR, 1'b0};
    vecs[3]  = '{1'b0, KindL, 1'b0};
    vecs[4]  = '{1'b0, KindR, 1'b0};
    vecs[5]  = '{1'b0, KindL, 1'b1};
    vecs[6]  = '{1'b0, KindR, 1'b0};
    vecs[7]  = '{1'b1, KindL, 1'b0};
    vecs[8]  = '{1'b0, KindR, 1'b0};
    vecs[9]  = '{1'b0, KindL, 1'b1};
    vecs[10] = '{1'b0, KindR, 1'b0};
    vecs[11] = '{1'b0, KindL, 1'b1};
    vecs[12] = '{1'b1, KindL, 1'b0};
    vecs[13] = '{1'b0, KindR, 1'b0};
    vecs[14] = '{1'b0, KindBoth, 1'b0};
    vecs[15] = '{1'b0, KindL, 1'b1};

    // Reset state held with switches idle.
    repeat (3) @(negedge clk);
    check("reset_hold", 1'b0);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    check("after_reset", 1'b0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) do_reset();
      press(vecs[i].kind, 1);
      check($sformatf("vec%0d", i), vecs[i].exp_led);
    end

    // Latency: LED rises exactly at edge k+2 after the final L is first sampled.
    do_reset();
    press(KindL, 1);
    press(KindR, 1);
    @(negedge clk);
    sw_if.PUSH_SW_LEFT = 1'b1;
    @(posedge clk); #1;
    sw_if.PUSH_SW_LEFT = 1'b0;
    check("lat_k", 1'b0);
    @(posedge clk); #1;
    check("lat_k1", 1'b0);
    @(posedge clk); #1;
    check("lat_k2", 1'b1);
    hist.push_back(0);
    repeat (5) @(negedge clk);
    check("lat_stays", 1'b1);

    // Asynchronous reset while in MATCH: LED drops before any clock edge.
    @(posedge clk); #2;
    rstb = 1'b0;
    #1;
    check("async_rst", 1'b0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    hist.delete();
    repeat (5) @(negedge clk);

    // Long LEFT hold counts once.
    press(KindL, 20);
    press(KindR, 1);
    press(KindL, 1);
    check("hold_left", 1'b1);
    // Long RIGHT hold must not re-trigger (would fall back to IDLE).
    press(KindR, 20);
    check("hold_right", 1'b0);
    press(KindL, 1);
    check("hold_right_then_l", 1'b1);

    // Back-to-back alternating presses in consecutive cycles.
    do_reset();
    @(negedge clk);
    sw_if.PUSH_SW_LEFT = 1'b1;
    @(negedge clk);
    sw_if.PUSH_SW_LEFT  = 1'b0;
    sw_if.PUSH_SW_RIGHT = 1'b1;
    @(negedge clk);
    sw_if.PUSH_SW_RIGHT = 1'b0;
    sw_if.PUSH_SW_LEFT  = 1'b1;
    @(negedge clk);
    sw_if.PUSH_SW_LEFT = 1'b0;
    repeat (5) @(negedge clk);
    check("back_to_back", 1'b1);

    // Switch held through reset release must not produce a pulse.
    @(negedge clk);
    rstb = 1'b0;
    sw_if.PUSH_SW_LEFT = 1'b1;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    hist.delete();
    repeat (10) @(negedge clk);
    sw_if.PUSH_SW_LEFT = 1'b0;
    repeat (4) @(negedge clk);
    press(KindR, 1);
    press(KindL, 1);
    check("held_through_reset", 1'b0);
    press(KindR, 1);
    press(KindL, 1);
    check("held_through_reset_then_match", 1'b1);

    // Random presses against the history model.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      int kind;
      int r;
      r = int'($urandom_range(0, 9));
      kind = (r < 5) ? KindL : (r < 9) ? KindR : KindBoth;
      press(kind, int'($urandom_range(1, 4)));
      check($sformatf("rand%0d", i), model_led());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
